// File: rtl/sram_access_seq.sv
// sram_access_seq: req/done sequencer for a 1Mx16 async SRAM.
// Registered strobes, programmable wait states, owns the data bus.
module sram_access_seq #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_PAD    = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   req,
  input  logic                   wr,
  input  logic [1:0]             be,
  input  logic [15:0]            addr,
  input  logic [15:0]            wdata,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            rdata,
  output logic                   CE,
  output logic                   UB,
  output logic                   LB,
  output logic                   OE,
  output logic                   WE,
  output logic [ADDR_PAD+15:0]   ADDR,
  inout  wire  [15:0]            Data
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    FINISH
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt;
  logic                  r_wr;
  logic [15:0]           r_wdata;
  logic                  r_drv;
  logic                  w_drv;
  logic                  w_lat;
  logic                  w_rlat;
  logic                  w_ce;
  logic                  w_ub;
  logic                  w_lb;
  logic                  w_oe;
  logic                  w_we;
  logic                  w_done;
  logic [ADDR_PAD+15:0]  w_addr;

  // Bus is only ever driven by writes, so it never fights an OE-low read.
  assign Data = r_drv ? r_wdata : 'z;

  // State register and wait counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
    end
  end

  // Next state plus the strobe values the next state must present.
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_drv  = r_drv;
    w_lat  = 1'b0;
    w_rlat = 1'b0;
    w_ce   = CE;
    w_ub   = UB;
    w_lb   = LB;
    w_oe   = 1'b1;
    w_we   = 1'b1;
    w_done = 1'b0;
    w_addr = ADDR;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_next = SETUP;
          w_lat  = 1'b1;
          w_addr = {{ADDR_PAD{1'b0}}, addr};
          w_ce   = 1'b0;
          w_ub   = ~be[1];
          w_lb   = ~be[0];
          w_oe   = wr;
          w_drv  = wr;
        end else begin
          w_ce  = 1'b1;
          w_ub  = 1'b1;
          w_lb  = 1'b1;
          w_drv = 1'b0;
        end
      end
      SETUP: begin
        w_next = ACCESS;
        w_cnt  = 4'(WAIT_CYCLES);
        w_oe   = r_wr;
        w_we   = ~r_wr;
      end
      ACCESS: begin
        w_cnt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next = FINISH;
          w_done = 1'b1;
          w_rlat = ~r_wr;
        end else begin
          w_oe = r_wr;
          w_we = ~r_wr;
        end
      end
      FINISH: begin
        w_next = IDLE;
        w_ce   = 1'b1;
        w_ub   = 1'b1;
        w_lb   = 1'b1;
        w_drv  = 1'b0;
      end
    endcase
  end

  // Registered SRAM strobes, address and handshake outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      CE    <= 1'b1;
      UB    <= 1'b1;
      LB    <= 1'b1;
      OE    <= 1'b1;
      WE    <= 1'b1;
      ADDR  <= '0;
      r_drv <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      CE    <= w_ce;
      UB    <= w_ub;
      LB    <= w_lb;
      OE    <= w_oe;
      WE    <= w_we;
      ADDR  <= w_addr;
      r_drv <= w_drv;
      busy  <= (w_next != IDLE);
      done  <= w_done;
    end
  end

  // Request capture and read data latch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wr    <= 1'b0;
      r_wdata <= 16'd0;
      rdata   <= 16'd0;
    end else begin
      if (w_lat) begin
        r_wr    <= wr;
        r_wdata <= wdata;
      end
      if (w_rlat) rdata <= Data;
    end
  end

endmodule

// File: tb/tb_sram_access_seq.sv
// tb_sram_access_seq: random and directed checks of sram_access_seq
// against a word-level SRAM reference model.
module tb_sram_access_seq;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [15:0] addr = 16'd0;
  logic [15:0] wdata = 16'd0;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  bit   [15:0] sram [1024];
  bit   [15:0] ref_mem [1024];
  logic [15:0] ref_rdata = 16'd0;
  logic [15:0] w_sram_out;
  logic        probe_en = 1'b0;
  logic [15:0] probe_val = 16'h5A3C;

  int checks = 0;
  int errors = 0;

  sram_access_seq #(
    .WAIT_CYCLES(W),
    .ADDR_PAD(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .req(req),
    .wr(wr),
    .be(be),
    .addr(addr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .rdata(rdata),
    .CE(CE),
    .UB(UB),
    .LB(LB),
    .OE(OE),
    .WE(WE),
    .ADDR(ADDR),
    .Data(Data)
  );

  always #5 Clk = ~Clk;

  // Async SRAM: drives on CE/OE low; bench probe drives only when bus must float.
  assign w_sram_out = sram[ADDR[9:0]];
  assign Data = probe_en ? probe_val :
                ((!CE && !OE && WE) ? w_sram_out : 'z);

  // SRAM write while CE and WE are low, per enabled byte.
  always @(negedge Clk) begin
    if (Reset && !CE && !WE) begin
      if (!UB) sram[ADDR[9:0]][15:8] <= Data[15:8];
      if (!LB) sram[ADDR[9:0]][7:0]  <= Data[7:0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic probe_float(input string name);
    probe_en = 1'b1;
    #1;
    checks++;
    if (Data !== probe_val) begin
      errors++;
      $display("FAIL %s float: bus %h, required %h (undriven)",
               name, Data, probe_val);
    end
    probe_en = 1'b0;
  endtask

  // One access, checked cycle by cycle from acceptance to the idle cycle after.
  task automatic do_access(input logic i_wr, input logic [1:0] i_be,
                           input logic [15:0] i_addr,
                           input logic [15:0] i_wdata, input bit keep);
    logic [15:0] exp_rd;
    logic [6:0]  exp_s;
    logic [6:0]  got_s;
    logic        exp_oe;
    logic        exp_we;
    bit          in_acc;
    @(negedge Clk);
    req   = 1'b1;
    wr    = i_wr;
    be    = i_be;
    addr  = i_addr;
    wdata = i_wdata;
    exp_rd = ref_mem[i_addr[9:0]];
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge Clk);
      #1;
      in_acc = (k <= W + 2);
      exp_oe = !(!i_wr && k <= W + 1);
      exp_we = !(i_wr && k >= 2 && k <= W + 1);
      exp_s = in_acc ?
        {1'b0, ~i_be[1], ~i_be[0], exp_oe, exp_we, 1'b1, 1'(k == W + 2)} :
        7'b1111100;
      got_s = {CE, UB, LB, OE, WE, busy, done};
      checks++;
      if (got_s !== exp_s) begin
        errors++;
        $display("FAIL strobes a=%h wr=%0d k=%0d: CE,UB,LB,OE,WE,busy,done=%b required %b",
                 i_addr, i_wr, k, got_s, exp_s);
      end
      if (in_acc) begin
        checks++;
        if (ADDR !== {4'h0, i_addr}) begin
          errors++;
          $display("FAIL addr k=%0d: ADDR %h required %h",
                   k, ADDR, {4'h0, i_addr});
        end
      end
      if (in_acc && i_wr) begin
        checks++;
        if (Data !== i_wdata) begin
          errors++;
          $display("FAIL wbus k=%0d: Data %h required %h", k, Data, i_wdata);
        end
      end else if (in_acc && !exp_oe) begin
        checks++;
        if (Data !== exp_rd) begin
          errors++;
          $display("FAIL rbus k=%0d: Data %h required %h", k, Data, exp_rd);
        end
      end
      if (k == W + 2) begin
        if (!i_wr) ref_rdata = exp_rd;
        checks++;
        if (rdata !== ref_rdata) begin
          errors++;
          $display("FAIL rdata a=%h: rdata %h required %h",
                   i_addr, rdata, ref_rdata);
        end
      end
      if (k == W + 3) probe_float("idle");
      if (k <= W + 1) begin
        req   = keep ? 1'b1 : 1'($urandom);
        wr    = 1'($urandom);
        be    = 2'($urandom);
        addr  = 16'($urandom);
        wdata = 16'($urandom);
      end else begin
        req = keep;
      end
    end
    if (i_wr) begin
      if (i_be[1]) ref_mem[i_addr[9:0]][15:8] = i_wdata[15:8];
      if (i_be[0]) ref_mem[i_addr[9:0]][7:0]  = i_wdata[7:0];
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    ref_rdata = 16'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      req   = 1'($urandom);
      wr    = 1'($urandom);
      be    = 2'($urandom);
      addr  = 16'($urandom);
      wdata = 16'($urandom);
      @(posedge Clk);
      #1;
      checks++;
      if ({CE, UB, LB, OE, WE, busy, done} !== 7'b1111100) begin
        errors++;
        $display("FAIL reset strobes: %b required 1111100",
                 {CE, UB, LB, OE, WE, busy, done});
      end
      checks++;
      if (rdata !== 16'd0 || ADDR !== 20'd0) begin
        errors++;
        $display("FAIL reset regs: rdata %h ADDR %h required 0 0", rdata, ADDR);
      end
      probe_float("reset");
    end
    @(negedge Clk);
    req = 1'b0;
    Reset = 1'b1;
    repeat (2) begin
      @(posedge Clk);
      #1;
      checks++;
      if ({CE, UB, LB, OE, WE, busy, done} !== 7'b1111100) begin
        errors++;
        $display("FAIL post-reset idle: %b required 1111100",
                 {CE, UB, LB, OE, WE, busy, done});
      end
    end
  endtask

  task automatic test_single_read();
    do_access(1'b1, 2'b11, 16'h1234, 16'hBEEF, 1'b0);
    do_access(1'b0, 2'b11, 16'h1234, 16'h0000, 1'b0);
    checks++;
    if (rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_read: rdata %h required BEEF", rdata);
    end
  endtask

  task automatic test_single_write();
    do_access(1'b1, 2'b11, 16'h0040, 16'h0F0F, 1'b0);
    checks++;
    if (sram[10'h040] !== 16'h0F0F) begin
      errors++;
      $display("FAIL single_write: mem %h required 0F0F", sram[10'h040]);
    end
  endtask

  task automatic test_byte_write();
    do_access(1'b1, 2'b11, 16'h0100, 16'h1234, 1'b0);
    do_access(1'b1, 2'b01, 16'h0100, 16'hAA55, 1'b0);
    do_access(1'b0, 2'b11, 16'h0100, 16'h0000, 1'b0);
    checks++;
    if (sram[10'h100] !== 16'h1255 || rdata !== 16'h1255) begin
      errors++;
      $display("FAIL byte_write: mem %h rdata %h required 1255",
               sram[10'h100], rdata);
    end
  endtask

  task automatic test_boundary();
    do_access(1'b0, 2'b00, 16'hFFFF, 16'h0000, 1'b0);
    do_access(1'b1, 2'b10, 16'h0155, 16'h9C3A, 1'b0);
    do_access(1'b0, 2'b11, 16'h0155, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_access(1'($urandom), 2'($urandom), 16'($urandom_range(0, 15)),
                16'($urandom), 1'b1);
    req = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_access(1'($urandom), 2'($urandom), 16'($urandom_range(0, 31)),
                16'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    req   = 1'b1;
    wr    = 1'b1;
    be    = 2'b11;
    addr  = 16'h0200;
    wdata = 16'hC3C3;
    @(posedge Clk);
    #1;
    req = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (WE !== 1'b0 || Data !== 16'hC3C3) begin
      errors++;
      $display("FAIL mid-write: WE %b Data %h required 0 C3C3", WE, Data);
    end
    Reset = 1'b0;
    ref_rdata = 16'd0;
    #1;
    checks++;
    if ({CE, UB, LB, OE, WE, busy, done} !== 7'b1111100) begin
      errors++;
      $display("FAIL reset_mid strobes: %b required 1111100",
               {CE, UB, LB, OE, WE, busy, done});
    end
    probe_float("reset_mid");
    repeat (3) begin
      @(posedge Clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid done: %b required 0", done);
      end
    end
    @(negedge Clk);
    Reset = 1'b1;
    do_access(1'b0, 2'b11, 16'h0040, 16'h0000, 1'b0);
    checks++;
    if (rdata !== 16'h0F0F) begin
      errors++;
      $display("FAIL reset_mid read: rdata %h required 0F0F", rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_byte_write();
    test_boundary();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
